// File: rtl/bakraid_pcm_fetch.sv
// bakraid_pcm_fetch: YMZ280B sample-ROM byte fetch from three SDRAM banks
// through a small direct-mapped byte cache.
module bakraid_pcm_fetch #(
    parameter int TIMEOUT = 1023,
    parameter int LINES   = 4
) (
    input  logic        CLK96,
    input  logic        RESET96_N,
    input  logic        ROM_RD,
    input  logic [23:0] ROM_ADDR,
    output logic [7:0]  ROM_DOUT,
    output logic        ROM_VALID,
    output logic        PCM_CS,
    output logic        PCM1_CS,
    output logic        PCM2_CS,
    output logic [21:0] PCM_ADDR,
    output logic [21:0] PCM1_ADDR,
    output logic [21:0] PCM2_ADDR,
    input  logic        PCM_OK,
    input  logic        PCM1_OK,
    input  logic        PCM2_OK,
    input  logic [7:0]  PCM_DOUT,
    input  logic [7:0]  PCM1_DOUT,
    input  logic [7:0]  PCM2_DOUT,
    output logic        BUSY,
    output logic        TMO_ERR
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 24 - IW;
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t           state;
    logic [2:0]       cs;
    logic [21:0]      addr;
    logic [23:0]      lat_addr;
    logic [CW-1:0]    cnt;
    logic [LINES-1:0] line_valid;
    logic [TW-1:0]    line_tag [LINES];
    logic [7:0]       line_data [LINES];
    logic [IW-1:0]    rd_idx;
    logic [IW-1:0]    lat_idx;
    logic             oor;
    logic             hit;
    logic             ok_sel;
    logic             accept;
    logic             expire;
    logic [7:0]       dout_sel;
    assign rd_idx    = ROM_ADDR[IW-1:0];
    assign lat_idx   = lat_addr[IW-1:0];
    assign oor       = ROM_ADDR[23:22] == 2'd3;
    assign hit       = line_valid[rd_idx] && line_tag[rd_idx] == ROM_ADDR[23:IW];
    // cs is one-hot in REQ and zero elsewhere, so it doubles as the bank select
    assign ok_sel    = (cs[0] & PCM_OK) | (cs[1] & PCM1_OK) | (cs[2] & PCM2_OK);
    assign dout_sel  = cs[1] ? PCM1_DOUT : cs[2] ? PCM2_DOUT : PCM_DOUT;
    assign accept    = state == REQ && cnt != '0 && ok_sel;
    assign expire    = state == REQ && cnt == CW'(TIMEOUT - 1);
    assign PCM_CS    = cs[0];
    assign PCM1_CS   = cs[1];
    assign PCM2_CS   = cs[2];
    assign PCM_ADDR  = addr;
    assign PCM1_ADDR = addr;
    assign PCM2_ADDR = addr;
    assign BUSY      = state != IDLE;
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            state      <= IDLE;
            cs         <= '0;
            addr       <= '0;
            lat_addr   <= '0;
            cnt        <= '0;
            line_valid <= '0;
            ROM_DOUT   <= 8'h00;
            ROM_VALID  <= 1'b0;
            TMO_ERR    <= 1'b0;
        end else begin
            ROM_VALID <= 1'b0;
            case (state)
                IDLE: if (ROM_RD) begin
                    if (oor || hit) begin
                        ROM_DOUT  <= oor ? 8'h00 : line_data[rd_idx];
                        ROM_VALID <= 1'b1;
                        state     <= DONE;
                    end else begin
                        lat_addr <= ROM_ADDR;
                        addr     <= ROM_ADDR[21:0];
                        cs       <= 3'b001 << ROM_ADDR[23:22];
                        cnt      <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (accept || expire) begin
                        ROM_DOUT  <= accept ? dout_sel : 8'h00;
                        TMO_ERR   <= TMO_ERR | ~accept;
                        if (accept) line_valid[lat_idx] <= 1'b1;
                        cs        <= '0;
                        ROM_VALID <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge CLK96) begin
        if (accept) begin
            line_tag[lat_idx]  <= lat_addr[23:IW];
            line_data[lat_idx] <= dout_sel;
        end
    end
endmodule

// File: tb/tb_bakraid_pcm_fetch.sv
// tb_bakraid_pcm_fetch: directed reads against modelled SDRAM banks,
// returned bytes checked through an expected-data queue.
module tb_bakraid_pcm_fetch;
    logic        CLK96     = 1'b0;
    logic        RESET96_N = 1'b0;
    logic        ROM_RD    = 1'b0;
    logic [23:0] ROM_ADDR  = '0;
    logic [7:0]  ROM_DOUT;
    logic        ROM_VALID;
    logic        PCM_CS, PCM1_CS, PCM2_CS;
    logic [21:0] PCM_ADDR, PCM1_ADDR, PCM2_ADDR;
    logic [7:0]  d0, d1, d2;
    logic        BUSY, TMO_ERR;
    logic [2:0]  ok_v     = '0;
    logic [2:0]  force_ok = '0;
    logic [2:0]  en       = 3'b111;
    logic [2:0]  cs_v;
    logic [2:0]  cs_hist  = '0;
    logic [21:0] last_addr [3];
    int          dly  [3] = '{2, 2, 2};
    int          rcnt [3] = '{0, 0, 0};
    int          total = 0, bad = 0, vcount = 0;
    logic [7:0]  exp_q [$];

    always #5 CLK96 = ~CLK96;

    function automatic logic [7:0] bdat(input int b, input logic [21:0] a);
        return 8'(a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]}) + 8'(60 * (b + 1));
    endfunction

    assign cs_v = {PCM2_CS, PCM1_CS, PCM_CS};
    assign d0 = bdat(0, PCM_ADDR);
    assign d1 = bdat(1, PCM1_ADDR);
    assign d2 = bdat(2, PCM2_ADDR);

    bakraid_pcm_fetch #(.TIMEOUT(8), .LINES(4)) dut (
        .CLK96(CLK96), .RESET96_N(RESET96_N), .ROM_RD(ROM_RD), .ROM_ADDR(ROM_ADDR),
        .ROM_DOUT(ROM_DOUT), .ROM_VALID(ROM_VALID),
        .PCM_CS(PCM_CS), .PCM1_CS(PCM1_CS), .PCM2_CS(PCM2_CS),
        .PCM_ADDR(PCM_ADDR), .PCM1_ADDR(PCM1_ADDR), .PCM2_ADDR(PCM2_ADDR),
        .PCM_OK(ok_v[0]), .PCM1_OK(ok_v[1]), .PCM2_OK(ok_v[2]),
        .PCM_DOUT(d0), .PCM1_DOUT(d1), .PCM2_DOUT(d2),
        .BUSY(BUSY), .TMO_ERR(TMO_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // bank responders and scoreboard consumer, all on the falling edge
    always @(negedge CLK96) begin
        cs_hist = cs_hist | cs_v;
        if (PCM_CS)  last_addr[0] = PCM_ADDR;
        if (PCM1_CS) last_addr[1] = PCM1_ADDR;
        if (PCM2_CS) last_addr[2] = PCM2_ADDR;
        for (int b = 0; b < 3; b++) begin
            rcnt[b] = cs_v[b] ? rcnt[b] + 1 : 0;
            ok_v[b] = force_ok[b] | (cs_v[b] & en[b] & (rcnt[b] >= dly[b]));
        end
        if (ROM_VALID) begin
            vcount++;
            chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("rom_dout", 32'(ROM_DOUT), 32'(exp_q.pop_front()));
        end
    end

    task automatic rd(input string tag, input logic [23:0] a, input logic [7:0] e,
                      input int lat, input logic [2:0] cs_exp);
        int n;
        cs_hist = '0;
        vcount  = 0;
        @(negedge CLK96);
        ROM_ADDR = a;
        ROM_RD   = 1'b1;
        exp_q.push_back(e);
        @(posedge CLK96);
        #1 ROM_RD = 1'b0;
        n = 1;
        while (!ROM_VALID && n < 40) begin
            @(posedge CLK96);
            #1 n++;
        end
        chk({tag, "_valid"}, 32'(ROM_VALID), 32'd1);
        if (lat > 0) chk({tag, "_latency"}, 32'(n), 32'(lat));
        @(posedge CLK96);
        #1;
        chk({tag, "_pulses"}, 32'(vcount), 32'd1);
        chk({tag, "_cs"}, 32'(cs_hist), 32'(cs_exp));
    endtask

    initial begin
        repeat (3) @(posedge CLK96);
        #1;
        chk("rst_cs", 32'(cs_v), 32'd0);
        chk("rst_addr", 32'(PCM_ADDR | PCM1_ADDR | PCM2_ADDR), 32'd0);
        chk("rst_dout", 32'(ROM_DOUT), 32'd0);
        chk("rst_valid", 32'(ROM_VALID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_tmo", 32'(TMO_ERR), 32'd0);
        @(negedge CLK96);
        RESET96_N = 1'b1;

        force_ok = 3'b101;
        dly[1] = 3;
        rd("bank1_miss", 24'h400123, bdat(1, 22'h000123), 4, 3'b010);
        chk("bank1_addr", 32'(last_addr[1]), 32'h000123);
        force_ok = '0;
        rd("bank1_hit", 24'h400123, bdat(1, 22'h000123), 1, 3'b000);
        rd("out_of_range", 24'hC00000, 8'h00, 1, 3'b000);

        force_ok[0] = 1'b1;
        dly[0] = 5;
        rd("stale_ok", 24'h000010, bdat(0, 22'h000010), 3, 3'b001);
        force_ok = '0;
        dly[0] = 2;

        chk("tmo_before", 32'(TMO_ERR), 32'd0);
        en[2] = 1'b0;
        rd("timeout", 24'h800040, 8'h00, 0, 3'b100);
        chk("tmo_after", 32'(TMO_ERR), 32'd1);
        en[2] = 1'b1;
        rd("timeout_refetch", 24'h800040, bdat(2, 22'h000040), 3, 3'b100);

        rd("conflict_a", 24'h000004, bdat(0, 22'h000004), 3, 3'b001);
        rd("conflict_b", 24'h000008, bdat(0, 22'h000008), 3, 3'b001);
        rd("conflict_a2", 24'h000004, bdat(0, 22'h000004), 3, 3'b001);
        rd("conflict_a_hit", 24'h000004, bdat(0, 22'h000004), 1, 3'b000);

        dly[1] = 20;
        @(negedge CLK96);
        ROM_ADDR = 24'h400200;
        ROM_RD   = 1'b1;
        @(posedge CLK96);
        #1 ROM_RD = 1'b0;
        chk("abort_cs_up", 32'(PCM1_CS), 32'd1);
        @(negedge CLK96);
        RESET96_N = 1'b0;
        #1;
        chk("abort_cs_drop", 32'(cs_v), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_tmo_clear", 32'(TMO_ERR), 32'd0);
        @(negedge CLK96);
        RESET96_N = 1'b1;
        dly[1] = 2;
        rd("post_reset_miss", 24'h400123, bdat(1, 22'h000123), 3, 3'b010);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
